sdram_port: RTL and testbench



---
 rtl/sdram_pkg.sv | 29 ++
 rtl/sdram_port_tag_queue.sv | 64 ++++++
 rtl/sdram_port.sv | 139 +++++++++++++
 tb/tb_sdram_port.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared field layout and helpers for the SDRAM host port and controller.
// The request word is {write, bank, row, column, wdata}.
package sdram_pkg;

  localparam int REQ_W      = 41;
  localparam int REQ_WR_BIT = 40;
  localparam int BANK_MSB   = 39;
  localparam int BANK_LSB   = 38;
  localparam int ROW_MSB    = 37;
  localparam int ROW_LSB    = 25;
  localparam int COL_MSB    = 24;
  localparam int COL_LSB    = 16;
  localparam int DATA_W     = 16;

  typedef enum logic {
    POP_IDLE,
    POP_HOLD
  } pop_state_e;

  function automatic logic [REQ_W-1:0] pack_req(
    input logic              wr,
    input logic [23:0]       addr,
    input logic [DATA_W-1:0] wdata
  );
    return {wr, addr[23:22], addr[21:9], addr[8:0],
            wr ? wdata : {DATA_W{1'b0}}};
  endfunction

endpackage

// File: rtl/sdram_port_tag_queue.sv
// Expected-response-type FIFO: one bit per in-flight request.
// Its count doubles as the outstanding-transaction counter.
module sdram_tag_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             push_tag,
  input  logic             pop,
  output logic             head,
  output logic [CNT_W-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (push) begin
      mem_d[wr_q] = push_tag;
      wr_d        = nxt(wr_q);
    end
    if (pop) begin
      rd_d = nxt(rd_q);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  assign head  = mem_q[rd_q];
  assign count = count_q;

endmodule

// File: rtl/sdram_port.sv
// Host-side front end: packs requests into the controller FIFO and
// decodes responses into read-data and write-ack pulses.
module sdram_port
  import sdram_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 4
) (
  input  logic              clk_48,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [23:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              wr_ack,
  output logic              err_mismatch,
  output logic              err_unexpected,
  output logic [CNT_W-1:0]  outstanding,
  output logic [REQ_W-1:0]  fifo_to_dram_data,
  output logic              fifo_to_dram_write_flag,
  input  logic              fifo_to_dram_full_flag,
  input  logic [REQ_W-1:0]  fifo_from_dram_data,
  output logic              fifo_from_dram_read_flag,
  input  logic              fifo_from_dram_empty_flag
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  pop_state_e        state_q, state_d;
  logic              push_q, push_d;
  logic [REQ_W-1:0]  data_q, data_d;
  logic              pop_q, pop_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              wr_ack_q, wr_ack_d;
  logic              err_mm_q, err_mm_d;
  logic              err_ue_q, err_ue_d;

  logic              accept;
  logic              q_pop;
  logic              q_head;
  logic [CNT_W-1:0]  q_count;
  logic              rsp_wr;

  assign req_ready = !rst && !fifo_to_dram_full_flag &&
                     (q_count < MAX_CNT) && !push_q;
  assign accept    = req_valid && req_ready;
  assign rsp_wr    = fifo_from_dram_data[REQ_WR_BIT];

  sdram_tag_queue #(
    .DEPTH (MAX_OUTSTANDING),
    .CNT_W (CNT_W)
  ) u_tag_queue (
    .clk      (clk_48),
    .rst      (rst),
    .push     (accept),
    .push_tag (req_write),
    .pop      (q_pop),
    .head     (q_head),
    .count    (q_count)
  );

  always_comb begin
    state_d     = state_q;
    push_d      = accept;
    data_d      = data_q;
    pop_d       = 1'b0;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    wr_ack_d    = 1'b0;
    err_mm_d    = err_mm_q;
    err_ue_d    = err_ue_q;
    q_pop       = 1'b0;
    if (accept) begin
      data_d = pack_req(req_write, req_addr, req_wdata);
    end
    unique case (state_q)
      POP_IDLE: begin
        if (!fifo_from_dram_empty_flag) begin
          pop_d   = 1'b1;
          state_d = POP_HOLD;
          if (q_count != '0) begin
            q_pop = 1'b1;
            if (rsp_wr != q_head) err_mm_d = 1'b1;
            if (rsp_wr) begin
              wr_ack_d = 1'b1;
            end else begin
              rsp_valid_d = 1'b1;
              rdata_d     = fifo_from_dram_data[DATA_W-1:0];
            end
          end else begin
            err_ue_d = 1'b1;
          end
        end
      end
      // gives the response FIFO a cycle to update empty after the pop
      POP_HOLD: state_d = POP_IDLE;
      default:  state_d = POP_IDLE;
    endcase
  end

  always_ff @(posedge clk_48) begin
    if (rst) begin
      state_q     <= POP_IDLE;
      push_q      <= 1'b0;
      data_q      <= '0;
      pop_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      wr_ack_q    <= 1'b0;
      err_mm_q    <= 1'b0;
      err_ue_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      push_q      <= push_d;
      data_q      <= data_d;
      pop_q       <= pop_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      wr_ack_q    <= wr_ack_d;
      err_mm_q    <= err_mm_d;
      err_ue_q    <= err_ue_d;
    end
  end

  assign fifo_to_dram_data        = data_q;
  assign fifo_to_dram_write_flag  = push_q;
  assign fifo_from_dram_read_flag = pop_q;
  assign rsp_valid                = rsp_valid_q;
  assign rsp_rdata                = rdata_q;
  assign wr_ack                   = wr_ack_q;
  assign err_mismatch             = err_mm_q;
  assign err_unexpected           = err_ue_q;
  assign outstanding              = q_count;

endmodule

// File: tb/tb_sdram_port.sv
// Directed bench for sdram_port with a show-ahead response FIFO model.
// Expected values are hand-computed constants.
module tb_sdram_port;

  logic        clk_48 = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [23:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        wr_ack;
  logic        err_mismatch;
  logic        err_unexpected;
  logic [3:0]  outstanding;
  logic [40:0] fifo_to_dram_data;
  logic        fifo_to_dram_write_flag;
  logic        fifo_to_dram_full_flag;
  logic [40:0] fifo_from_dram_data;
  logic        fifo_from_dram_read_flag;
  logic        fifo_from_dram_empty_flag;

  int checks   = 0;
  int failures = 0;

  logic [40:0] rmem [16];
  logic [3:0]  rhead = '0;
  logic [3:0]  rtail = '0;

  always #5 clk_48 = ~clk_48;

  assign fifo_from_dram_empty_flag = (rhead == rtail);
  assign fifo_from_dram_data       = rmem[rhead];

  always @(posedge clk_48) begin
    if (fifo_from_dram_read_flag && (rhead != rtail)) rhead <= rhead + 4'd1;
  end

  sdram_port #(
    .MAX_OUTSTANDING (4),
    .CNT_W           (4)
  ) dut (
    .clk_48                    (clk_48),
    .rst                       (rst),
    .req_valid                 (req_valid),
    .req_ready                 (req_ready),
    .req_write                 (req_write),
    .req_addr                  (req_addr),
    .req_wdata                 (req_wdata),
    .rsp_valid                 (rsp_valid),
    .rsp_rdata                 (rsp_rdata),
    .wr_ack                    (wr_ack),
    .err_mismatch              (err_mismatch),
    .err_unexpected            (err_unexpected),
    .outstanding               (outstanding),
    .fifo_to_dram_data         (fifo_to_dram_data),
    .fifo_to_dram_write_flag   (fifo_to_dram_write_flag),
    .fifo_to_dram_full_flag    (fifo_to_dram_full_flag),
    .fifo_from_dram_data       (fifo_from_dram_data),
    .fifo_from_dram_read_flag  (fifo_from_dram_read_flag),
    .fifo_from_dram_empty_flag (fifo_from_dram_empty_flag)
  );

  task automatic tick();
    @(posedge clk_48);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic inject(input logic [40:0] w);
    rmem[rtail] = w;
    rtail       = rtail + 4'd1;
  endtask

  initial begin
    rst                    = 1'b1;
    req_valid              = 1'b0;
    req_write              = 1'b0;
    req_addr               = '0;
    req_wdata              = '0;
    fifo_to_dram_full_flag = 1'b0;
    repeat (3) tick();

    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_wr_ack", wr_ack, 0);
    chk("rst_errs", {err_mismatch, err_unexpected}, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_req_data", fifo_to_dram_data, 0);
    chk("rst_flags", {fifo_to_dram_write_flag, fifo_from_dram_read_flag}, 0);

    rst = 1'b0;
    #1;
    chk("ready_after_rst", req_ready, 1);

    // write C0_0203 / BEEF
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 24'hC0_0203;
    req_wdata = 16'hBEEF;
    tick();
    req_valid = 1'b0;
    chk("wr_push_flag", fifo_to_dram_write_flag, 1);
    chk("wr_push_data", fifo_to_dram_data,
        {1'b1, 2'b11, 13'h0001, 9'h003, 16'hBEEF});
    chk("wr_outstanding", outstanding, 1);
    chk("wr_ready_gap", req_ready, 0);
    tick();
    chk("wr_push_flag_off", fifo_to_dram_write_flag, 0);
    chk("wr_data_hold", fifo_to_dram_data,
        {1'b1, 2'b11, 13'h0001, 9'h003, 16'hBEEF});
    inject({1'b1, 24'h0, 16'h0});
    tick();
    chk("wack_read_flag", fifo_from_dram_read_flag, 1);
    chk("wack_pulse", wr_ack, 1);
    chk("wack_no_rsp", rsp_valid, 0);
    chk("wack_outstanding", outstanding, 0);
    tick();
    chk("wack_read_flag_off", fifo_from_dram_read_flag, 0);
    chk("wack_pulse_off", wr_ack, 0);

    // read addr 0; wdata must be ignored
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 24'h0;
    req_wdata = 16'hFFFF;
    tick();
    req_valid = 1'b0;
    chk("rd_push_flag", fifo_to_dram_write_flag, 1);
    chk("rd_push_data", fifo_to_dram_data, 0);
    tick();
    inject({1'b0, 24'h0, 16'h1234});
    tick();
    chk("rd_read_flag", fifo_from_dram_read_flag, 1);
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rdata", rsp_rdata, 16'h1234);
    chk("rd_errs", {err_mismatch, err_unexpected}, 0);
    chk("rd_outstanding", outstanding, 0);
    tick();
    chk("rd_rsp_valid_off", rsp_valid, 0);
    chk("rd_rdata_hold", rsp_rdata, 16'h1234);

    // saturate with 4 reads, accept every other cycle
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 24'h00_0040;
    for (int k = 0; k <= 8; k++) begin
      chk($sformatf("sat_ready_%0d", k), req_ready,
          ((k % 2 == 0) && (k < 8)) ? 1 : 0);
      tick();
    end
    chk("sat_outstanding", outstanding, 4);
    chk("sat_ready_blocked", req_ready, 0);
    inject({1'b0, 24'h0, 16'hA000});
    tick();
    chk("sat_ready_back", req_ready, 1);
    chk("sat_out_dec", outstanding, 3);
    chk("sat_rdata", rsp_rdata, 16'hA000);
    req_valid = 1'b0;
    tick();

    // two queued responses: pops two cycles apart
    inject({1'b0, 24'h0, 16'h0B01});
    inject({1'b0, 24'h0, 16'h0B02});
    tick();
    chk("b2b_pop1", fifo_from_dram_read_flag, 1);
    chk("b2b_data1", rsp_rdata, 16'h0B01);
    chk("b2b_out1", outstanding, 2);
    tick();
    chk("b2b_gap", fifo_from_dram_read_flag, 0);
    chk("b2b_gap_rsp", rsp_valid, 0);
    tick();
    chk("b2b_pop2", fifo_from_dram_read_flag, 1);
    chk("b2b_data2", rsp_rdata, 16'h0B02);
    chk("b2b_out2", outstanding, 1);
    tick();
    chk("b2b_gap2", fifo_from_dram_read_flag, 0);
    inject({1'b0, 24'h0, 16'h0B03});
    tick();
    chk("drain_out", outstanding, 0);
    chk("drain_errs", {err_mismatch, err_unexpected}, 0);
    tick();

    // write answered by a read-type response
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 24'h00_0010;
    req_wdata = 16'h1111;
    tick();
    req_valid = 1'b0;
    tick();
    inject({1'b0, 24'h0, 16'h5555});
    tick();
    chk("mm_err", err_mismatch, 1);
    chk("mm_rsp_valid", rsp_valid, 1);
    chk("mm_rdata", rsp_rdata, 16'h5555);
    chk("mm_no_ack", wr_ack, 0);
    chk("mm_out", outstanding, 0);
    chk("mm_no_unexp", err_unexpected, 0);
    tick();

    inject({1'b1, 24'h0, 16'h0});
    tick();
    chk("ue_err", err_unexpected, 1);
    chk("ue_pop", fifo_from_dram_read_flag, 1);
    chk("ue_no_pulses", {rsp_valid, wr_ack}, 0);
    chk("ue_out", outstanding, 0);
    repeat (3) tick();
    chk("errs_sticky", {err_mismatch, err_unexpected}, 2'b11);

    // full flag blocks accepts
    fifo_to_dram_full_flag = 1'b1;
    req_valid = 1'b1;
    #1;
    chk("full_blocks", req_ready, 0);
    tick();
    chk("full_no_push", fifo_to_dram_write_flag, 0);
    fifo_to_dram_full_flag = 1'b0;
    req_write = 1'b0;
    #1;
    chk("full_release", req_ready, 1);
    tick();
    req_valid = 1'b0;
    chk("pre_rst_out", outstanding, 1);

    rst = 1'b1;
    tick();
    chk("rst2_errs", {err_mismatch, err_unexpected}, 0);
    chk("rst2_out", outstanding, 0);
    chk("rst2_ready", req_ready, 0);
    rst = 1'b0;
    tick();
    chk("rst2_ready_back", req_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
